// File: rtl/fifo_param_pkg.sv
// Shared encodings for the parametrised FIFO: operation-state values and their width.
package fifo_param_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WR_ERR  = 3'd2,
    ST_NO_OP   = 3'd3,
    ST_READ    = 3'd4,
    ST_RD_ERR  = 3'd5,
    ST_RDWR    = 3'd6,
    ST_ILLEGAL = 3'd7
  } state_e;

endpackage

// File: rtl/fifo_param_ns.sv
// Combinational accept decode and next-state for the FIFO; depends only on requests and occupancy.
module fifo_param_ns
  import fifo_param_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_WIDTH:0]  data_count,
  output logic [STATE_W-1:0]   next_state,
  output logic                 do_write,
  output logic                 do_read,
  output logic                 wr_ack_nx,
  output logic                 wr_err_nx,
  output logic                 rd_ack_nx,
  output logic                 rd_err_nx
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

  logic is_empty, is_full;

  assign is_empty = (data_count == '0);
  assign is_full  = (data_count == DEPTH_C);

  // A write into a full FIFO still lands when a read frees the oldest slot at the same edge.
  assign do_write  = wr_en && (!is_full || rd_en);
  assign do_read   = rd_en && !is_empty;
  assign wr_ack_nx = do_write;
  assign wr_err_nx = wr_en && !do_write;
  assign rd_ack_nx = do_read;
  assign rd_err_nx = rd_en && !do_read;

  always_comb begin
    next_state = ST_NO_OP;
    case ({wr_en, rd_en})
      2'b10:   next_state = do_write ? ST_WRITE : ST_WR_ERR;
      2'b01:   next_state = do_read  ? ST_READ  : ST_RD_ERR;
      2'b11:   next_state = do_read  ? ST_RDWR  : ST_WRITE;
      default: next_state = ST_NO_OP;
    endcase
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: storage, pointers, occupancy, flags and debug state register.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [2:0]            state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [STATE_W-1:0]    state_q, next_state;
  logic                  do_write, do_read;
  logic                  wr_ack_nx, wr_err_nx, rd_ack_nx, rd_err_nx;

  fifo_param_ns #(.ADDR_WIDTH(ADDR_WIDTH)) u_ns (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .data_count (data_count),
    .next_state (next_state),
    .do_write   (do_write),
    .do_read    (do_read),
    .wr_ack_nx  (wr_ack_nx),
    .wr_err_nx  (wr_err_nx),
    .rd_ack_nx  (rd_ack_nx),
    .rd_err_nx  (rd_err_nx)
  );

  // Storage is never cleared; reset only blocks the write that shares its edge.
  always_ff @(posedge clk) begin
    if (!reset && do_write) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      dout       <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_read) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        dout   <= mem[rd_ptr];
      end
      case ({do_write, do_read})
        2'b10:   data_count <= data_count + (ADDR_WIDTH+1)'(1);
        2'b01:   data_count <= data_count - (ADDR_WIDTH+1)'(1);
        default: data_count <= data_count;
      endcase
    end
  end

  // State register; next state never depends on the current one, so an illegal value self-clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      state_q <= next_state;
      wr_ack  <= wr_ack_nx;
      wr_err  <= wr_err_nx;
      rd_ack  <= rd_ack_nx;
      rd_err  <= rd_err_nx;
    end
  end

  assign state        = state_q;
  assign full         = (data_count == DEPTH_C);
  assign empty        = (data_count == '0);
  assign almost_full  = (data_count >= AF_C);
  assign almost_empty = (data_count <= AE_C);

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus random traffic against a queue model.
module tb_fifo_param;

  localparam int DW = 32, AW = 3, DEPTH = 8, AF = 6, AE = 2;

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_en;
  logic [DW-1:0] din, dout;
  logic [AW:0]   data_count;
  logic          full, empty, almost_full, almost_empty;
  logic          wr_ack, wr_err, rd_ack, rd_err;
  logic [2:0]    state;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_wack, m_werr, m_rack, m_rerr;
  logic [2:0]    m_state;

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din), .dout(dout),
    .data_count(data_count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack),
    .rd_err(rd_err), .state(state)
  );

  always #5 clk = ~clk;

  // Drive one edge and advance the model by the same request, then settle past the edge.
  task automatic step(input logic w, input logic r, input logic rs, input logic [DW-1:0] d);
    int c;
    reset = rs; wr_en = w; rd_en = r; din = d;
    c = q.size();
    m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
    if (rs) begin
      q.delete(); m_dout = '0; m_state = 3'd0;
    end else if (w && r) begin
      if (c > 0) begin
        m_dout = q.pop_front(); q.push_back(d);
        m_wack = 1; m_rack = 1; m_state = 3'd6;
      end else begin
        q.push_back(d); m_wack = 1; m_rerr = 1; m_state = 3'd1;
      end
    end else if (w) begin
      if (c < DEPTH) begin q.push_back(d); m_wack = 1; m_state = 3'd1; end
      else begin m_werr = 1; m_state = 3'd2; end
    end else if (r) begin
      if (c > 0) begin m_dout = q.pop_front(); m_rack = 1; m_state = 3'd4; end
      else begin m_rerr = 1; m_state = 3'd5; end
    end else m_state = 3'd3;
    @(posedge clk);
    #1;
    reset = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    checks++; if (state !== 3'd0 || dout !== '0) begin errors++;
      $display("FAIL reset_state: state=%0d dout=%h want state=0 dout=0", state, dout); end
    step(0, 0, 0, '0);
    checks++; if (state !== 3'd3 || data_count !== 0 || empty !== 1 || almost_empty !== 1 ||
                  full !== 0 || almost_full !== 0) begin errors++;
      $display("FAIL reset_idle: state=%0d cnt=%0d e=%b ae=%b f=%b af=%b want 3,0,1,1,0,0",
               state, data_count, empty, almost_empty, full, almost_full); end
    checks++; if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0) begin errors++;
      $display("FAIL reset_acks: got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err}); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, DW'(32'h11 * i));
      checks++; if (wr_ack !== 1 || wr_err !== 0 || data_count !== (AW+1)'(i) ||
                    almost_full !== (i >= AF)) begin errors++;
        $display("FAIL fill_%0d: ack=%b err=%b cnt=%0d af=%b want 1,0,%0d,%b",
                 i, wr_ack, wr_err, data_count, almost_full, i, i >= AF); end
    end
    checks++; if (full !== 1 || data_count !== 8) begin errors++;
      $display("FAIL fill_full: full=%b cnt=%0d want 1,8", full, data_count); end
    step(1, 0, 0, 32'hDEAD);
    checks++; if (wr_err !== 1 || wr_ack !== 0 || state !== 3'd2 || data_count !== 8) begin errors++;
      $display("FAIL overflow: err=%b ack=%b state=%0d cnt=%0d want 1,0,2,8",
               wr_err, wr_ack, state, data_count); end
  endtask

  task automatic test_full_rdwr();
    step(1, 1, 0, 32'h99);
    checks++; if (dout !== 32'h11 || rd_ack !== 1 || wr_ack !== 1 || data_count !== 8 ||
                  state !== 3'd6) begin errors++;
      $display("FAIL full_rdwr: dout=%h rack=%b wack=%b cnt=%0d state=%0d want 11,1,1,8,6",
               dout, rd_ack, wr_ack, data_count, state); end
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] exp;
      exp = (i < 7) ? DW'(32'h22 + 32'h11 * i) : 32'h99;
      step(0, 1, 0, '0);
      checks++; if (dout !== exp || rd_ack !== 1) begin errors++;
        $display("FAIL drain_%0d: dout=%h rack=%b want %h,1", i, dout, rd_ack, exp); end
    end
    checks++; if (empty !== 1 || data_count !== 0) begin errors++;
      $display("FAIL drain_empty: empty=%b cnt=%0d want 1,0", empty, data_count); end
  endtask

  task automatic test_empty_read();
    step(0, 1, 0, '0);
    checks++; if (rd_err !== 1 || rd_ack !== 0 || state !== 3'd5 || dout !== 32'h99) begin errors++;
      $display("FAIL underflow: err=%b ack=%b state=%0d dout=%h want 1,0,5,99",
               rd_err, rd_ack, state, dout); end
  endtask

  task automatic test_empty_rdwr();
    step(1, 1, 0, 32'hAB);
    checks++; if (wr_ack !== 1 || rd_err !== 1 || rd_ack !== 0 || data_count !== 1 ||
                  state !== 3'd1 || dout !== 32'h99) begin errors++;
      $display("FAIL empty_rdwr: wack=%b rerr=%b rack=%b cnt=%0d state=%0d dout=%h want 1,1,0,1,1,99",
               wr_ack, rd_err, rd_ack, data_count, state, dout); end
    step(0, 1, 0, '0);
    checks++; if (dout !== 32'hAB) begin errors++;
      $display("FAIL empty_rdwr_read: dout=%h want ab", dout); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] d;
      d = $urandom;
      step(1, 0, 0, d);
      step(0, 1, 0, '0);
      checks++; if (dout !== d || empty !== 1) begin errors++;
        $display("FAIL wrap_%0d: dout=%h empty=%b want %h,1", i, dout, empty, d); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 0, 0, DW'(i + 100));
    step(1, 0, 1, 32'h55);
    checks++; if (data_count !== 0 || empty !== 1 || state !== 3'd0 || wr_ack !== 0) begin errors++;
      $display("FAIL reset_mid: cnt=%0d empty=%b state=%0d wack=%b want 0,1,0,0",
               data_count, empty, state, wr_ack); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [DW+AW+13:0] got, exp;
      int sz;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), $urandom);
      sz = q.size();
      exp = {m_dout, (AW+1)'(sz), sz == DEPTH, sz == 0, sz >= AF, sz <= AE,
             m_wack, m_werr, m_rack, m_rerr, m_state};
      got = {dout, data_count, full, empty, almost_full, almost_empty,
             wr_ack, wr_err, rd_ack, rd_err, state};
      checks++; if (got !== exp) begin errors++;
        $display("FAIL random_%0d: got=%h want=%h", i, got, exp); end
    end
  endtask

  initial begin
    reset = 1; wr_en = 0; rd_en = 0; din = '0;
    m_dout = '0; m_state = 3'd0;
    m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
    test_reset();
    test_fill();
    test_full_rdwr();
    test_empty_read();
    test_empty_rdwr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
